// File: rtl/frame_pkg.sv
// Shared constants and types for the magic-number frame link.
// Used by the receive deframer and the CRC helper.
package frame_pkg;

    localparam logic [7:0]  MAGIC_B0    = 8'hDA;
    localparam logic [7:0]  MAGIC_B1    = 8'hBB;
    localparam logic [7:0]  MAGIC_B2    = 8'hAD;
    localparam logic [7:0]  MAGIC_B3    = 8'h00;
    localparam logic [31:0] MAGICNUMBER = 32'hDABBAD00;

    localparam logic [7:0]  ACK = 8'h06;
    localparam logic [7:0]  NAK = 8'h15;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CRC_HI  = 2'd2,
        CRC_LO  = 2'd3
    } frame_state_e;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = MAGIC_B0;
            2'd1:    b = MAGIC_B1;
            2'd2:    b = MAGIC_B2;
            default: b = MAGIC_B3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte combinational step of CRC-16/CCITT-FALSE, MSB first.
// Shared with the frame transmitter.
module crc16_ccitt_byte
    import frame_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {i_data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (w_crc[15]) begin
                w_crc = {w_crc[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_crc = {w_crc[14:0], 1'b0};
            end
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer: hunts DA BB AD 00, collects payload + CRC-16, checks it.
// Define FRAME_ACK_EN to emit ACK/NAK codes toward uart_tx.
module uart_frame_rx
    import frame_pkg::*;
#(
    parameter int PAYLOAD_BYTES  = 4,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       rx_data_ready,
    input  logic [7:0]                 rx_data,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       frame_valid,
    output logic                       crc_error,
    output logic                       timeout,
    output logic                       busy,
    output logic                       ack_valid,
    output logic [7:0]                 ack_byte
);

    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int CW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);
    localparam logic [IW-1:0] TMO_MAX  = IW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] TMO_LAST = IW'(TIMEOUT_CYCLES - 1);

    frame_state_e  r_state;
    logic [1:0]    r_hdr_idx;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_crc;
    logic [7:0]    r_crc_hi;
    logic [PW-1:0] r_shadow;
    logic [PW-1:0] r_payload;
    logic [IW-1:0] r_idle;
    logic          r_frame_valid;
    logic          r_crc_error;
    logic          r_timeout;

    frame_state_e  w_state;
    logic [1:0]    w_hdr_idx;
    logic [CW-1:0] w_cnt;
    logic [15:0]   w_crc;
    logic [7:0]    w_crc_hi;
    logic [PW-1:0] w_shadow;
    logic [PW-1:0] w_payload;
    logic [IW-1:0] w_idle;
    logic          w_good;
    logic          w_bad;
    logic          w_expire;
    logic [15:0]   w_crc_next;

    crc16_ccitt_byte u_crc (
        .i_crc  (r_crc),
        .i_data (rx_data),
        .o_crc  (w_crc_next)
    );

    // A byte landing on the expiry cycle suppresses the timeout.
    assign w_expire = (r_state != HUNT) && !rx_data_ready
                      && (r_idle == TMO_LAST);

    always_comb begin
        if (rx_data_ready || (r_state == HUNT)) begin
            w_idle = '0;
        end else if (r_idle != TMO_MAX) begin
            w_idle = r_idle + 1'b1;
        end else begin
            w_idle = r_idle;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_hdr_idx = r_hdr_idx;
        w_cnt     = r_cnt;
        w_crc     = r_crc;
        w_crc_hi  = r_crc_hi;
        w_shadow  = r_shadow;
        w_payload = r_payload;
        w_good    = 1'b0;
        w_bad     = 1'b0;

        if (w_expire) begin
            w_state   = HUNT;
            w_hdr_idx = 2'd0;
        end else if (rx_data_ready) begin
            unique case (r_state)
                HUNT: begin
                    if (rx_data == magic_byte(r_hdr_idx)) begin
                        if (r_hdr_idx == 2'd3) begin
                            w_state   = PAYLOAD;
                            w_hdr_idx = 2'd0;
                            w_cnt     = '0;
                            w_crc     = CRC_INIT;
                        end else begin
                            w_hdr_idx = r_hdr_idx + 2'd1;
                        end
                    end else if (rx_data == MAGIC_B0) begin
                        w_hdr_idx = 2'd1;
                    end else begin
                        w_hdr_idx = 2'd0;
                    end
                end
                PAYLOAD: begin
                    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                        if (r_cnt == CW'(i)) begin
                            w_shadow[8*i +: 8] = rx_data;
                        end
                    end
                    w_crc = w_crc_next;
                    if (r_cnt == LAST_IDX) begin
                        w_state = CRC_HI;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                CRC_HI: begin
                    w_crc_hi = rx_data;
                    w_state  = CRC_LO;
                end
                CRC_LO: begin
                    w_state   = HUNT;
                    w_hdr_idx = 2'd0;
                    if ({r_crc_hi, rx_data} == r_crc) begin
                        w_payload = r_shadow;
                        w_good    = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                default: begin
                    w_state   = HUNT;
                    w_hdr_idx = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_hdr_idx     <= 2'd0;
            r_cnt         <= '0;
            r_crc         <= CRC_INIT;
            r_crc_hi      <= 8'h00;
            r_shadow      <= '0;
            r_payload     <= '0;
            r_idle        <= '0;
            r_frame_valid <= 1'b0;
            r_crc_error   <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_hdr_idx     <= w_hdr_idx;
            r_cnt         <= w_cnt;
            r_crc         <= w_crc;
            r_crc_hi      <= w_crc_hi;
            r_shadow      <= w_shadow;
            r_payload     <= w_payload;
            r_idle        <= w_idle;
            r_frame_valid <= w_good;
            r_crc_error   <= w_bad;
            r_timeout     <= w_expire;
        end
    end

    assign payload     = r_payload;
    assign frame_valid = r_frame_valid;
    assign crc_error   = r_crc_error;
    assign timeout     = r_timeout;
    assign busy        = (r_state != HUNT);

`ifdef FRAME_ACK_EN
    logic       r_ack_valid;
    logic [7:0] r_ack_byte;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_ack_valid <= 1'b0;
            r_ack_byte  <= 8'h00;
        end else begin
            r_ack_valid <= w_good | w_bad;
            if (w_good) begin
                r_ack_byte <= ACK;
            end else if (w_bad) begin
                r_ack_byte <= NAK;
            end
        end
    end

    assign ack_valid = r_ack_valid;
    assign ack_byte  = r_ack_byte;
`else
    assign ack_valid = 1'b0;
    assign ack_byte  = 8'h00;
`endif

endmodule
